// File: rtl/memory_pkg.sv
// Shared widths and request layout for the ray-memory arbiter.
package memory_pkg;

    localparam int DATA_WIDTH_DEFAULT    = 24;
    localparam int ADDRESS_WIDTH_DEFAULT = 32;
    localparam int ID_WIDTH_DEFAULT      = 4;

    typedef struct packed {
        logic [ADDRESS_WIDTH_DEFAULT-1:0] address;
        logic [DATA_WIDTH_DEFAULT-1:0]    data;
        logic                             write;
        logic [ID_WIDTH_DEFAULT-1:0]      id;
    } mem_req_t;

    function automatic int wrapIncrement(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_picker #(
    parameter int N = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] win,
    output logic [N-1:0]     grant
);

    logic [PTR_W-1:0] idx;

    // Scan from the farthest offset down so the closest hit to ptr is written last.
    always_comb begin
        any   = 1'b0;
        win   = '0;
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
        if (any) grant[win] = 1'b1;
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin N:1 memory request arbiter with one registered output slice and ID-routed responses.
// Define MEMORY_ARBITER_STATS_EN to add grant/drop/stall counters.
module memory_arbiter
    import memory_pkg::*;
#(
    parameter int MASTERS       = 4,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
    parameter int ID_WIDTH      = ID_WIDTH_DEFAULT
`ifdef MEMORY_ARBITER_STATS_EN
    , parameter int STAT_WIDTH  = 16
`endif
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [MASTERS-1:0]                     m_msValid,
    output logic [MASTERS-1:0]                     m_msTaken,
    input  logic [MASTERS-1:0][ADDRESS_WIDTH-1:0]  m_msAddress,
    input  logic [MASTERS-1:0][DATA_WIDTH-1:0]     m_msData,
    input  logic [MASTERS-1:0]                     m_msWrite,
    input  logic [MASTERS-1:0][ID_WIDTH-1:0]       m_msID,
    output logic [MASTERS-1:0]                     m_smValid,
    input  logic [MASTERS-1:0]                     m_smTaken,
    output logic [DATA_WIDTH-1:0]                  m_smData,
    output logic [ID_WIDTH-1:0]                    m_smID,
    output logic                                   s_msValid,
    input  logic                                   s_msTaken,
    output logic [ADDRESS_WIDTH-1:0]               s_msAddress,
    output logic [DATA_WIDTH-1:0]                  s_msData,
    output logic                                   s_msWrite,
    output logic [ID_WIDTH-1:0]                    s_msID,
    input  logic                                   s_smValid,
    output logic                                   s_smTaken,
    input  logic [DATA_WIDTH-1:0]                  s_smData,
    input  logic [ID_WIDTH-1:0]                    s_smID
`ifdef MEMORY_ARBITER_STATS_EN
    ,
    output logic [MASTERS-1:0][STAT_WIDTH-1:0]     grantCount,
    output logic [STAT_WIDTH-1:0]                  dropCount,
    output logic [STAT_WIDTH-1:0]                  stallCycles
`endif
);

    localparam int PTR_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]    data;
        logic                     write;
        logic [ID_WIDTH-1:0]      id;
    } slot_t;

    state_t           state, nextState;
    slot_t            slot;
    logic [PTR_W-1:0] ptr;
    logic             anyReq, canAccept, load;
    logic [PTR_W-1:0] win;
    logic [MASTERS-1:0] grant;
    logic             idKnown, takenSel;

    rr_picker #(.N(MASTERS)) picker (
        .req   (m_msValid),
        .ptr   (ptr),
        .any   (anyReq),
        .win   (win),
        .grant (grant)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= EMPTY;
        else       state <= nextState;
    end

    // The slot can refill in the same cycle the slave drains it, giving one request per cycle.
    always_comb begin
        nextState = state;
        m_msTaken = '0;
        canAccept = (state == EMPTY) || (state == FULL && s_msTaken);
        load      = canAccept && anyReq;
        if (load) begin
            m_msTaken = grant;
            nextState = FULL;
        end else if (state == FULL && s_msTaken) begin
            nextState = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot <= '0;
            ptr  <= '0;
        end else if (load) begin
            slot <= '{address: m_msAddress[win], data: m_msData[win],
                      write: m_msWrite[win], id: m_msID[win]};
            ptr  <= PTR_W'(wrapIncrement(int'(win), MASTERS));
        end
    end

    assign s_msValid   = (state == FULL);
    assign s_msAddress = slot.address;
    assign s_msData    = slot.data;
    assign s_msWrite   = slot.write;
    assign s_msID      = slot.id;

    // IDs with no matching master are swallowed so the slave never blocks on them.
    always_comb begin
        m_smValid = '0;
        idKnown   = 1'b0;
        takenSel  = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            if (s_smID == ID_WIDTH'(i)) begin
                idKnown      = 1'b1;
                takenSel     = m_smTaken[i];
                m_smValid[i] = s_smValid;
            end
        end
    end

    assign s_smTaken = idKnown ? takenSel : s_smValid;
    assign m_smData  = s_smData;
    assign m_smID    = s_smID;

`ifdef MEMORY_ARBITER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            grantCount  <= '0;
            dropCount   <= '0;
            stallCycles <= '0;
        end else begin
            for (int i = 0; i < MASTERS; i++) begin
                if (m_msTaken[i] && grantCount[i] != '1)
                    grantCount[i] <= grantCount[i] + STAT_WIDTH'(1);
            end
            if (s_smValid && !idKnown && dropCount != '1)
                dropCount <= dropCount + STAT_WIDTH'(1);
            if (state == FULL && !s_msTaken && stallCycles != '1)
                stallCycles <= stallCycles + STAT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sits directly downstream of the ray memory masters (one per ray unit) and upstream of the single memory slave (DRAM/BRAM controller).
- Merges N master request channels into one slave request channel using round-robin arbitration.
- Routes each slave response back to the master whose index equals the response ID.
- Request path is registered, giving one output slice; response path is combinational.

Parameters:
- MASTERS, 4, number of master ports; master i must use bus ID i.
- DATA_WIDTH, 24, data word width.
- ADDRESS_WIDTH, 32, address width.
- ID_WIDTH, 4, width of msID/smID; must satisfy 2**ID_WIDTH >= MASTERS.
- STAT_WIDTH, 16, width of statistics counters (optional feature only).

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- m_msValid  in  MASTERS  per-master request valid.
- m_msTaken  out  MASTERS  per-master request accepted (1-cycle pulse).
- m_msAddress  in  MASTERS x ADDRESS_WIDTH  request address.
- m_msData  in  MASTERS x DATA_WIDTH  write data.
- m_msWrite  in  MASTERS  1 = write, 0 = read.
- m_msID  in  MASTERS x ID_WIDTH  master ID; forwarded unchanged.
- m_smValid  out  MASTERS  response valid for master i.
- m_smTaken  in  MASTERS  master i accepts the response.
- m_smData  out  DATA_WIDTH  response data, broadcast to all masters.
- m_smID  out  ID_WIDTH  response ID, broadcast to all masters.
- s_msValid, s_msAddress, s_msData, s_msWrite, s_msID  out  request to slave.
- s_msTaken  in  1  slave accepts the request.
- s_smValid, s_smData, s_smID  in  response from slave.
- s_smTaken  out  1  response accepted.

Behaviour:
- States are EMPTY and FULL (output register holds a request).
- Reset values:
  - state = EMPTY; rr pointer = 0.
  - s_msValid = 0; s_msAddress, s_msData, s_msWrite and s_msID = 0.
  - m_msTaken = 0; statistics counters = 0.
- Grant:
  - Round-robin is combinational over m_msValid.
  - Search starts at index ptr and wraps at MASTERS-1 to 0.
- Accept condition: canAccept = (state == EMPTY) || (state == FULL && s_msTaken).
- On a cycle with canAccept and any m_msValid asserted:
  - m_msTaken[win] = 1 in the same cycle; all other bits = 0.
  - The winner's address, data, write and ID are registered into the s_ms* outputs; state becomes FULL next cycle.
  - ptr <= (win + 1) mod MASTERS.
- FULL with s_msTaken and no new winner: state becomes EMPTY and s_msValid falls next cycle.
- Latency: a request accepted in cycle t appears on s_ms* in cycle t+1. Back-to-back throughput is 1 request per cycle.
- While FULL without s_msTaken, the s_ms* outputs are held stable.
- m_msTaken depends only on state, s_msTaken and m_msValid. It never depends on m_smTaken, so there is no combinational loop with the masters.
- Response routing (combinational):
  - m_smValid[i] = s_smValid && (s_smID == i).
  - m_smData = s_smData; m_smID = s_smID.
  - s_smTaken = m_smTaken[s_smID] when s_smID < MASTERS; otherwise s_smTaken = s_smValid, so a response with an unknown ID is dropped in one cycle.
- Requests and responses are independent: a grant and a response to the same master may occur in the same cycle.
- Reset mid-operation discards any held request; s_msValid = 0 from the next cycle.
- Masters must hold msValid and payload stable until msTaken. The arbiter does not check this.

Optional Feature:
- Macro: MEMORY_ARBITER_STATS_EN.
- When defined, extra outputs are added:
  - grantCount [MASTERS x STAT_WIDTH], incremented on each m_msTaken.
  - dropCount [STAT_WIDTH], incremented on each dropped unknown-ID response.
  - stallCycles [STAT_WIDTH], incremented on each cycle with state FULL && !s_msTaken.
- All counters saturate at all-ones and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- memory_pkg holds:
  - DATA_WIDTH_DEFAULT = 24, ADDRESS_WIDTH_DEFAULT = 32, ID_WIDTH_DEFAULT = 4.
  - The request struct typedef mem_req_t {address, data, write, id}.
- Sub-module rr_picker (parameter N):
  - Inputs: req[N], ptr.
  - Outputs: any, win index, one-hot grant.
  - Purely combinational, unit-tested separately.

Test Plan:
- Single master: reset, then m_msValid[2] = 1 with address 0x100, write = 0, ID 2, and the slave always taking.
  - Expect m_msTaken[2] in cycle t.
  - Expect s_msValid with address 0x100 and s_msID 2 in cycle t+1.
  - Expect s_msValid = 0 at t+2.
- Fairness: all 4 masters continuously valid and the slave always taking.
  - Expect grant order 0,1,2,3,0,1,… with one grant per cycle.
  - Expect grantCount of 25 each after 100 cycles (STATS_EN).
- Backpressure: s_msTaken held low for 5 cycles with masters 0 and 1 valid.
  - Expect the s_ms* outputs stable and no m_msTaken during the stall.
  - On release, expect the next grant in the same cycle as s_msTaken.
- Response routing: s_smValid with s_smID 3 and data 0xABCDEF while m_smTaken[3] = 0 for 2 cycles.
  - Expect only m_smValid[3] high and s_smTaken low.
  - Expect s_smTaken = 1 when m_smTaken[3] rises.
- Unknown ID: s_smID 9 with s_smValid.
  - Expect all m_smValid = 0 and s_smTaken = 1.
  - Expect dropCount to increment by 1.
- Reset while FULL and stalled: expect s_msValid = 0 the next cycle and the rr pointer back to 0 (master 0 wins the next contest).
